// File: rtl/keypoint_locator_pkg.sv
// Shared types, record layout and helpers for the keypoint locator.
package keypoint_locator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } kp_state_e;

  localparam int CNT_W     = 16;
  localparam int SCORE_W   = 8;
  localparam int SCORE_LSB = 0;
  localparam int X_LSB     = SCORE_LSB + SCORE_W;

  // Ceiling log2, floored at 1 so degenerate sizes still yield a legal width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/keypoint_locator_if.sv
// Response-stream input, record output and status bundle of the keypoint locator.
interface keypoint_locator_if #(
  parameter int XW = 9,
  parameter int YW = 8
);
  import keypoint_locator_pkg::*;

  logic               clear;
  logic               kp_valid;
  logic [SCORE_W-1:0] kp_data;
  logic               out_ready;
  logic               out_valid;
  logic [XW-1:0]      out_x;
  logic [YW-1:0]      out_y;
  logic [SCORE_W-1:0] out_score;
  logic               frame_done;
  logic [CNT_W-1:0]   frame_kp_count;
  logic [CNT_W-1:0]   drop_count;
  logic               overflow;

  modport master (
    output clear, kp_valid, kp_data, out_ready,
    input  out_valid, out_x, out_y, out_score,
    input  frame_done, frame_kp_count, drop_count, overflow
  );

  modport slave (
    input  clear, kp_valid, kp_data, out_ready,
    output out_valid, out_x, out_y, out_score,
    output frame_done, frame_kp_count, drop_count, overflow
  );

endinterface

// File: rtl/keypoint_locator_kp_fifo.sv
// First-word-fall-through record FIFO with full/empty flags and a held last-popped word.
// Latency: a push is visible on rd_dat the cycle after the edge that wrote it into an empty FIFO.
// Backpressure: push while full succeeds only if a pop happens in the same cycle; otherwise ignored.
module kp_fifo
  import keypoint_locator_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          push, pop;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);
  assign pop    = !clr && !empty && rd_rdy;
  assign push   = !clr && wr_vld && (!full || pop);
  assign rd_dat = empty ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      hold_d   = '0;
    end else begin
      // When full, wr_ptr == rd_ptr: the pop reads the old head before the slot is reused.
      if (push) begin
        mem_d[wr_ptr_q] = wr_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        hold_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/keypoint_locator.sv
// Raster-tracks the keypoint response stream and queues (x, y, score) records at or above THRESH.
// Latency: a kept pixel appears on out_* one cycle after acceptance when the FIFO was empty.
// Backpressure: out_ready stalls the FIFO; records arriving while it is full are dropped and counted.
module keypoint_locator
  import keypoint_locator_pkg::*;
#(
  parameter int          IMG_W  = 320,
  parameter int          IMG_H  = 240,
  parameter int          DEPTH  = 16,
  parameter logic [7:0]  THRESH = 8'd1
) (
  input  logic             clk,
  input  logic             rst,
  keypoint_locator_if.slave bus
);

  localparam int XW = clog2(IMG_W);
  localparam int YW = clog2(IMG_H);
  localparam int RW = XW + YW + SCORE_W;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  kp_state_e        state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;
  logic             frame_done_q, frame_done_d;

  logic             kp_hit, last_pix, pop, drop, push_ok;
  logic             fifo_full, fifo_empty;
  logic [RW-1:0]    wr_dat, rd_dat;

  assign kp_hit   = !bus.clear && bus.kp_valid && (bus.kp_data >= THRESH);
  assign last_pix = bus.kp_valid && (x_q == X_LAST) && (y_q == Y_LAST);
  assign pop      = !fifo_empty && bus.out_ready;
  assign drop     = kp_hit && fifo_full && !pop;
  assign push_ok  = kp_hit && !drop;
  assign wr_dat   = {y_q, x_q, bus.kp_data};

  kp_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.clear),
    .wr_vld (kp_hit),
    .wr_dat (wr_dat),
    .rd_rdy (bus.out_ready),
    .rd_dat (rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    run_cnt_d    = run_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    ovf_d        = ovf_q;
    frame_done_d = 1'b0;
    if (bus.clear) begin
      state_d     = ST_IDLE;
      x_d         = '0;
      y_d         = '0;
      run_cnt_d   = '0;
      frame_cnt_d = '0;
      drop_cnt_d  = '0;
      ovf_d       = 1'b0;
    end else begin
      if (bus.kp_valid) begin
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end

      case (state_q)
        ST_IDLE: if (bus.kp_valid) state_d = last_pix ? ST_DONE : ST_RUN;
        ST_RUN:  if (last_pix) state_d = ST_DONE;
        ST_DONE: state_d = last_pix ? ST_DONE : (bus.kp_valid ? ST_RUN : ST_IDLE);
        default: state_d = ST_IDLE;
      endcase

      // Snapshot includes the last pixel's push; the DONE-cycle pixel then starts the next frame's count.
      if (last_pix) begin
        frame_cnt_d = sat_inc(run_cnt_q, push_ok);
        run_cnt_d   = '0;
      end else begin
        run_cnt_d   = sat_inc(run_cnt_q, push_ok);
      end
      frame_done_d = (state_d == ST_DONE);

      drop_cnt_d = sat_inc(drop_cnt_q, drop);
      ovf_d      = ovf_q | drop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      run_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      run_cnt_q    <= run_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.out_valid      = !fifo_empty;
  assign bus.out_score      = rd_dat[SCORE_LSB +: SCORE_W];
  assign bus.out_x          = rd_dat[X_LSB +: XW];
  assign bus.out_y          = rd_dat[X_LSB + XW +: YW];
  assign bus.frame_done     = frame_done_q;
  assign bus.frame_kp_count = frame_cnt_q;
  assign bus.drop_count     = drop_cnt_q;
  assign bus.overflow       = ovf_q;

endmodule
